// File: rtl/clint_if.sv
// Signal bundle between the core-local interrupt controller and the pipeline/CSR file.
// The master modport is the controller side; the slave modport is the core side.
interface clint_if;
    logic [7:0]  int_flag_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        div_started_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        global_int_en_i;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] data_o;
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    modport master (
        input  int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i, div_started_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
        output we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );

    modport slave (
        output int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i, div_started_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
        input  we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );
endinterface

// File: rtl/clint.sv
// Core-local interrupt/trap controller: sequences trap-entry and mret CSR writes, then redirects the PC.
// Optional: define CLINT_EBREAK_EN to decode EBREAK as a synchronous trap (cause 3).
module clint (
    input  logic     clk,
    input  logic     rst,
    clint_if.master  bus
);
    localparam logic [31:0] INST_ECALL   = 32'h00000073;
    localparam logic [31:0] INST_EBREAK  = 32'h00100073;
    localparam logic [31:0] INST_MRET    = 32'h30200073;
    localparam logic [31:0] CSR_MSTATUS  = 32'h00000300;
    localparam logic [31:0] CSR_MEPC     = 32'h00000341;
    localparam logic [31:0] CSR_MCAUSE   = 32'h00000342;
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_INT    = 32'h80000007;

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, ASSERT, W_MSTATUS_MRET, ASSERT_MRET
    } state_t;

    state_t      state, next_state;
    logic [31:0] epc, cause, epc_next, cause_next;
    logic        sync_trap, async_trap, mret;
    logic [31:0] sync_cause;
    logic        we_next, assert_next;
    logic [31:0] waddr_next, data_next, int_addr_next, mstatus_mod;

    always_comb begin
        sync_trap  = (bus.inst_i == INST_ECALL);
        sync_cause = CAUSE_ECALL;
`ifdef CLINT_EBREAK_EN
        if (bus.inst_i == INST_EBREAK) begin
            sync_trap  = 1'b1;
            sync_cause = CAUSE_EBREAK;
        end
`else
        if (bus.inst_i == INST_EBREAK) begin
            sync_trap  = 1'b0;
        end
`endif
        async_trap = (bus.int_flag_i != '0) && bus.global_int_en_i && !bus.div_started_i;
        mret       = (bus.inst_i == INST_MRET);
    end

    always_comb begin
        next_state = state;
        epc_next   = epc;
        cause_next = cause;
        unique case (state)
            IDLE: begin
                if (sync_trap) begin
                    next_state = W_MEPC;
                    epc_next   = bus.inst_addr_i;
                    cause_next = sync_cause;
                end else if (async_trap) begin
                    next_state = W_MEPC;
                    epc_next   = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
                    cause_next = CAUSE_INT;
                end else if (mret) begin
                    next_state = W_MSTATUS_MRET;
                end
            end
            W_MEPC:         next_state = W_MCAUSE;
            W_MCAUSE:       next_state = W_MSTATUS;
            W_MSTATUS:      next_state = ASSERT;
            ASSERT:         next_state = IDLE;
            W_MSTATUS_MRET: next_state = ASSERT_MRET;
            ASSERT_MRET:    next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    assign bus.hold_flag_o = (state != IDLE) || sync_trap || async_trap || mret;

    // Outputs are decoded from the upcoming state and registered, so each write
    // appears in the cycle the FSM sits in the corresponding state.
    always_comb begin
        we_next       = 1'b0;
        waddr_next    = '0;
        data_next     = '0;
        assert_next   = 1'b0;
        int_addr_next = '0;
        mstatus_mod   = bus.csr_mstatus_i;
        unique case (next_state)
            W_MEPC: begin
                we_next    = 1'b1;
                waddr_next = CSR_MEPC;
                data_next  = epc_next;
            end
            W_MCAUSE: begin
                we_next    = 1'b1;
                waddr_next = CSR_MCAUSE;
                data_next  = cause_next;
            end
            W_MSTATUS: begin
                mstatus_mod[7] = bus.csr_mstatus_i[3];
                mstatus_mod[3] = 1'b0;
                we_next        = 1'b1;
                waddr_next     = CSR_MSTATUS;
                data_next      = mstatus_mod;
            end
            W_MSTATUS_MRET: begin
                mstatus_mod[3] = bus.csr_mstatus_i[7];
                mstatus_mod[7] = 1'b1;
                we_next        = 1'b1;
                waddr_next     = CSR_MSTATUS;
                data_next      = mstatus_mod;
            end
            ASSERT: begin
                assert_next   = 1'b1;
                int_addr_next = bus.csr_mtvec_i;
            end
            ASSERT_MRET: begin
                assert_next   = 1'b1;
                int_addr_next = bus.csr_mepc_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            epc              <= '0;
            cause            <= '0;
            bus.we_o         <= 1'b0;
            bus.waddr_o      <= '0;
            bus.data_o       <= '0;
            bus.int_assert_o <= 1'b0;
            bus.int_addr_o   <= '0;
        end else begin
            state            <= next_state;
            epc              <= epc_next;
            cause            <= cause_next;
            bus.we_o         <= we_next;
            bus.waddr_o      <= waddr_next;
            bus.data_o       <= data_next;
            bus.int_assert_o <= assert_next;
            bus.int_addr_o   <= int_addr_next;
        end
    end
endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: expected CSR writes/redirects are queued with the stimulus and
// compared against the events the DUT produces.
module tb_clint;
    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] MRET   = 32'h30200073;
    localparam logic [31:0] NOP    = 32'h00000013;

    typedef struct packed {
        logic        kind;   // 0 = CSR write, 1 = redirect
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    clint_if bus();
    clint dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  total = 0;
    int  bad = 0;
    int  hold_cnt;
    int  overlap = 0;
    logic last_hold;

    // One cycle: sample at negedge, then return just after the next posedge.
    task automatic cyc();
        @(negedge clk);
        last_hold = bus.hold_flag_o;
        if (bus.hold_flag_o === 1'b1) hold_cnt++;
        if (bus.we_o === 1'b1) obs_q.push_back(ev_t'{1'b0, bus.waddr_o, bus.data_o});
        if (bus.int_assert_o === 1'b1) obs_q.push_back(ev_t'{1'b1, bus.int_addr_o, 32'h0});
        if (bus.we_o === 1'b1 && bus.int_assert_o === 1'b1) overlap++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        exp_q.delete();
        obs_q.delete();
        hold_cnt = 0;
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] mst, input logic [31:0] vec);
        exp_q.push_back(ev_t'{1'b0, 32'h341, epc});
        exp_q.push_back(ev_t'{1'b0, 32'h342, cause});
        exp_q.push_back(ev_t'{1'b0, 32'h300, mst});
        exp_q.push_back(ev_t'{1'b1, vec, 32'h0});
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({bus.we_o, bus.int_assert_o, bus.hold_flag_o} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {bus.we_o, bus.int_assert_o, bus.hold_flag_o});
        end
        total++;
        if ({bus.waddr_o, bus.data_o, bus.int_addr_o} !== 96'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {bus.waddr_o, bus.data_o, bus.int_addr_o});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ecall();
        clear();
        bus.inst_i = ECALL; bus.inst_addr_i = 32'h100;
        bus.csr_mtvec_i = 32'h400; bus.csr_mstatus_i = 32'h8;
        push_trap(32'h100, 32'd11, 32'h80, 32'h400);
        cyc();
        bus.inst_i = NOP;
        repeat (6) cyc();
        total++;
        if (hold_cnt !== 5) begin bad++; $display("FAIL ecall_hold got=%0d exp=5", hold_cnt); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL ecall_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL ecall_ev got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_async();
        clear();
        bus.inst_i = NOP; bus.inst_addr_i = 32'h200;
        bus.int_flag_i = 8'h01; bus.global_int_en_i = 1'b1;
        bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h2C;
        bus.csr_mstatus_i = 32'h8; bus.csr_mtvec_i = 32'h400;
        push_trap(32'h2C, 32'h80000007, 32'h80, 32'h400);
        cyc();
        bus.int_flag_i = 8'h00; bus.jump_flag_i = 1'b0;
        repeat (6) cyc();
        total++;
        if (hold_cnt !== 5) begin bad++; $display("FAIL async_hold got=%0d exp=5", hold_cnt); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL async_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL async_ev got=%h exp=%h", o, e); end
        end
        // Interrupts masked: nothing at all.
        clear();
        bus.int_flag_i = 8'h01; bus.global_int_en_i = 1'b0; bus.jump_flag_i = 1'b1;
        repeat (6) cyc();
        bus.int_flag_i = 8'h00; bus.jump_flag_i = 1'b0;
        total++;
        if (hold_cnt !== 0 || obs_q.size() !== 0) begin
            bad++; $display("FAIL masked got hold=%0d ev=%0d exp=0/0", hold_cnt, obs_q.size());
        end
    endtask

    task automatic test_div_defer();
        clear();
        bus.inst_i = NOP; bus.inst_addr_i = 32'h300; bus.jump_flag_i = 1'b0;
        bus.int_flag_i = 8'h80; bus.global_int_en_i = 1'b1; bus.div_started_i = 1'b1;
        bus.csr_mstatus_i = 32'h8; bus.csr_mtvec_i = 32'h480;
        repeat (10) cyc();
        total++;
        if (hold_cnt !== 0 || obs_q.size() !== 0) begin
            bad++; $display("FAIL div_defer got hold=%0d ev=%0d exp=0/0", hold_cnt, obs_q.size());
        end
        clear();
        bus.div_started_i = 1'b0;
        push_trap(32'h300, 32'h80000007, 32'h80, 32'h480);
        cyc();
        total++;
        if (last_hold !== 1'b1) begin bad++; $display("FAIL div_release_hold got=%b exp=1", last_hold); end
        bus.int_flag_i = 8'h00;
        repeat (6) cyc();
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL div_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL div_ev got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_mret();
        clear();
        bus.inst_i = MRET; bus.csr_mstatus_i = 32'h80; bus.csr_mepc_i = 32'h104;
        exp_q.push_back(ev_t'{1'b0, 32'h300, 32'h88});
        exp_q.push_back(ev_t'{1'b1, 32'h104, 32'h0});
        cyc();
        bus.inst_i = NOP;
        repeat (5) cyc();
        total++;
        if (hold_cnt !== 3) begin bad++; $display("FAIL mret_hold got=%0d exp=3", hold_cnt); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL mret_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL mret_ev got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_priority();
        clear();
        bus.inst_i = ECALL; bus.inst_addr_i = 32'h500;
        bus.int_flag_i = 8'h01; bus.global_int_en_i = 1'b1;
        bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h77C;
        bus.csr_mstatus_i = 32'h88; bus.csr_mtvec_i = 32'h600;
        push_trap(32'h500, 32'd11, 32'h80, 32'h600);
        cyc();
        bus.inst_i = NOP; bus.int_flag_i = 8'h00; bus.jump_flag_i = 1'b0;
        repeat (6) cyc();
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL prio_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL prio_ev got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_rst_mid();
        clear();
        bus.inst_i = ECALL; bus.inst_addr_i = 32'h140;
        bus.csr_mstatus_i = 32'h8; bus.csr_mtvec_i = 32'h400;
        exp_q.push_back(ev_t'{1'b0, 32'h341, 32'h140});
        exp_q.push_back(ev_t'{1'b0, 32'h342, 32'd11});
        cyc();              // T0
        bus.inst_i = NOP;
        cyc();              // T1
        rst = 1'b1;
        cyc();              // T2, reset taken at its closing edge
        rst = 1'b0;
        repeat (5) cyc();
        total++;
        if (hold_cnt !== 3) begin bad++; $display("FAIL rst_hold got=%0d exp=3", hold_cnt); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rst_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL rst_ev got=%h exp=%h", o, e); end
        end
        @(negedge clk);
        total++;
        if ({bus.we_o, bus.int_assert_o, bus.waddr_o, bus.data_o, bus.int_addr_o} !== 98'h0) begin
            bad++; $display("FAIL rst_outputs got we=%b as=%b exp=0", bus.we_o, bus.int_assert_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ebreak();
        clear();
        bus.inst_i = EBREAK; bus.inst_addr_i = 32'h180;
        bus.csr_mstatus_i = 32'h8; bus.csr_mtvec_i = 32'h400;
`ifdef CLINT_EBREAK_EN
        push_trap(32'h180, 32'd3, 32'h80, 32'h400);
`endif
        cyc();
        bus.inst_i = NOP;
        repeat (6) cyc();
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL ebreak_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL ebreak_ev got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_no_overlap();
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL we_assert_overlap got=%0d exp=0", overlap); end
    endtask

    initial begin
        rst = 1'b1;
        bus.int_flag_i = '0; bus.inst_i = NOP; bus.inst_addr_i = '0;
        bus.jump_flag_i = 1'b0; bus.jump_addr_i = '0; bus.div_started_i = 1'b0;
        bus.csr_mtvec_i = '0; bus.csr_mepc_i = '0; bus.csr_mstatus_i = '0;
        bus.global_int_en_i = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        #1 rst = 1'b0;
        test_ecall();
        test_async();
        test_div_defer();
        test_mret();
        test_priority();
        test_rst_mid();
        test_ebreak();
        test_no_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clint.md
# clint

Core-local interrupt and trap controller. Detects synchronous traps (`ecall`, `ebreak`), asynchronous interrupt requests and `mret` in the decode stage, then stalls the pipeline. It sequences the trap-entry and trap-return CSR writes into the CSR register file through that file's clint write port. Finally it redirects the PC through ex to the handler (`mtvec`) or the return address (`mepc`).

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `int_flag_i` in 8: level interrupt requests; bit0 is the timer.
- `inst_i` in 32: instruction currently in id.
- `inst_addr_i` in 32: PC of `inst_i`.
- `jump_flag_i` in 1: ex is taking a jump/branch this cycle.
- `jump_addr_i` in 32: target of that jump.
- `div_started_i` in 1: multi-cycle divide in flight in ex.
- `csr_mtvec_i` in 32, `csr_mepc_i` in 32, `csr_mstatus_i` in 32: current CSR values from the CSR register file.
- `global_int_en_i` in 1: `mstatus.MIE`.
- `we_o` out 1: CSR write enable to the CSR register file.
- `waddr_o` out 32: CSR write address; upper 20 bits are always 0.
- `data_o` out 32: CSR write data.
- `hold_flag_o` out 1: stalls pc/if/id/ex.
- `int_assert_o` out 1: one-cycle redirect strobe to ex.
- `int_addr_o` out 32: redirect target.

## Operation
- Fixed values:
  - Instruction encodings: ECALL `32'h00000073`, EBREAK `32'h00100073`, MRET `32'h30200073`.
  - CSR addresses: MSTATUS `0x300`, MTVEC `0x305`, MEPC `0x341`, MCAUSE `0x342`.
  - Cause codes: ecall `32'd11`, ebreak `32'd3`, interrupt `32'h80000007`.
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, ASSERT, W_MSTATUS_MRET, ASSERT_MRET.
- Trap detection happens only in IDLE, with priority sync > async > mret:
  - Sync trap: `inst_i` is ECALL, or EBREAK (see Configuration).
    - Latch `epc = inst_addr_i` and the matching cause.
    - Go to W_MEPC.
  - Async trap: `int_flag_i != 0`, `global_int_en_i == 1` and `div_started_i == 0`.
    - Latch `epc = jump_flag_i ? jump_addr_i : inst_addr_i` and cause `32'h80000007`.
    - Go to W_MEPC.
    - While `div_started_i` is high, the request is deferred rather than dropped; being level-sensitive, it is taken once the divide completes.
  - Mret: `inst_i` is MRET. Go to W_MSTATUS_MRET.
- CSR write data per state:
  - W_MEPC: write MEPC ← `epc`.
  - W_MCAUSE: write MCAUSE ← `cause`.
  - W_MSTATUS: write MSTATUS ← `csr_mstatus_i` with bit7 (MPIE) ← bit3 and bit3 (MIE) ← 0.
  - W_MSTATUS_MRET: write MSTATUS ← `csr_mstatus_i` with bit3 ← bit7 and bit7 ← 1.
- ASSERT: `int_assert_o = 1`, `int_addr_o = csr_mtvec_i`, then back to IDLE.
- ASSERT_MRET: `int_assert_o = 1`, `int_addr_o = csr_mepc_i`, then back to IDLE.
- `hold_flag_o` is combinational. It is high when a detect condition is true in IDLE, or whenever the state is not IDLE. This guarantees ex issues no CSR write while the FSM writes, since ex writes would take priority in the CSR register file.

## Timing
- Reset: state IDLE. All outputs 0: `we_o`, `waddr_o`, `data_o`, `int_assert_o`, `int_addr_o`, `hold_flag_o` (given no detect).
- `rst` asserted mid-sequence aborts the sequence at the next edge; no further writes or assert are issued.
- `we_o`, `waddr_o`, `data_o`, `int_assert_o` and `int_addr_o` are registered and active in the cycle after the state is entered.
- Trap: T0 is the detect cycle (hold high).
  - T1: MEPC write.
  - T2: MCAUSE write.
  - T3: MSTATUS write.
  - T4: `int_assert_o` pulse.
  - T5: IDLE.
  - Hold is high T0–T4.
- Mret: T0 detect, T1 MSTATUS write, T2 assert, T3 IDLE.
- Exactly one write per write cycle. `int_assert_o` is never high at the same time as `we_o`.
- New events arriving while not in IDLE are ignored; async requests persist because they are level-sensitive.

## Configuration
- `CLINT_EBREAK_EN` defined: EBREAK is a sync trap with cause 3.
- Not defined: EBREAK is not decoded; it passes through as a NOP with no hold and no writes.

## Test plan
- ECALL at `inst_addr_i=0x100`, `mtvec=0x400`, `mstatus=0x8` → writes in order MEPC=`0x100`, MCAUSE=`11`, MSTATUS=`0x80`; then `int_assert_o` with addr `0x400`; hold high for 5 cycles.
- `int_flag_i=0x01`, MIE=1, `jump_flag_i=1`, `jump_addr_i=0x2C` → MEPC=`0x2C`, MCAUSE=`0x80000007`. Repeat with MIE=0 → no hold, no writes.
- `div_started_i=1` with a pending interrupt for 10 cycles → no action. Dropping `div_started_i` to 0 → sequence starts that cycle.
- MRET with `mstatus=0x80`, `mepc=0x104` → MSTATUS=`0x88`, then assert with addr `0x104`; hold high for 3 cycles.
- ECALL and interrupt in the same cycle → cause `11` (sync wins).
- `rst` pulsed at T2 of a trap → no MSTATUS write, no assert, outputs 0.
- With `CLINT_EBREAK_EN` undefined, EBREAK → no activity. With it defined, EBREAK → MCAUSE=`3`.
